// File: rtl/serial_subtractor8.sv
// Bit-serial 8-bit subtractor: Diff = A - B - Bi, one bit per clock, LSB first.
// Bo exposes the per-stage borrow chain so it can be cross-checked against the adder's carries.
module serial_subtractor8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Bi,
  output logic       busy,
  output logic       done,
  output logic [7:0] Diff,
  output logic [7:0] Bo
);

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           brw;
  logic [IW-1:0]  idx;

  logic           a_bit_c;
  logic           b_bit_c;
  logic           d_bit_c;
  logic           nb_c;

  // Single full-subtractor cell on the currently selected bit.
  always_comb begin
    a_bit_c = a_q[idx];
    b_bit_c = b_q[idx];
    d_bit_c = a_bit_c ^ b_bit_c ^ brw;
    nb_c    = (~a_bit_c & b_bit_c) | (~(a_bit_c ^ b_bit_c) & brw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      brw   <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            brw   <= Bi;
            idx   <= '0;
            Diff  <= '0;
            Bo    <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          Diff[idx] <= d_bit_c;
          Bo[idx]   <= nb_c;
          brw       <= nb_c;
          idx       <= idx + IW'(1);
          if (idx == IW'(W - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed bench for serial_subtractor8: arithmetic vectors, handshake timing, reset abort, start hold.
module tb_serial_subtractor8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bi;
  logic       busy;
  logic       done;
  logic [7:0] Diff;
  logic [7:0] Bo;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bo    (Bo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ripple reference: adder stages with B inverted and carry-in = ~Bi; borrow = ~carry.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic [7:0] bo);
    logic c;
    logic nb;
    c = ~bi;
    for (int i = 0; i < 8; i++) begin
      nb    = ~b[i];
      d[i]  = a[i] ^ nb ^ c;
      c     = (a[i] & nb) | (a[i] & c) | (nb & c);
      bo[i] = ~c;
    end
  endtask

  // Pulses start for one accept edge, then counts edges until done (0 on timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output int lat, output int overlap);
    A = a; B = b; Bi = bi; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    overlap = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy && done) overlap++;
      tick();
      if (busy && done) overlap++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 8'hAA; B = 8'h55; Bi = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, done, Diff, Bo} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b Diff=%h Bo=%h, required all 0", busy, done, Diff, Bo);
    end
    rst = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_vec(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] exp_d, input logic [7:0] exp_bo);
    int lat;
    int ov;
    run_op(a, b, bi, lat, ov);
    vectors++;
    if (lat !== 8 || ov !== 0) begin
      miscompares++;
      $display("FAIL latency %h-%h-%b: done after %0d edges overlap=%0d, required 8 and 0", a, b, bi, lat, ov);
    end
    vectors++;
    if (Diff !== exp_d || Bo !== exp_bo) begin
      miscompares++;
      $display("FAIL vec %h-%h-%b: Diff=%h Bo=%h, required Diff=%h Bo=%h", a, b, bi, Diff, Bo, exp_d, exp_bo);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || Diff !== exp_d) begin
      miscompares++;
      $display("FAIL hold %h-%h: done=%b busy=%b Diff=%h, required 0 0 %h", a, b, done, busy, Diff, exp_d);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    A = 8'h10; B = 8'h01; Bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin A = 8'hFF; B = 8'h33; Bi = 1'b1; start = 1'b1; end
      else start = 1'b0;
      tick();
      if (done) dones++;
    end
    vectors++;
    if (dones !== 1 || Diff !== 8'h0F || Bo !== 8'h0F) begin
      miscompares++;
      $display("FAIL ignore_start: dones=%0d Diff=%h Bo=%h, required 1 0f 0f", dones, Diff, Bo);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    A = 8'hF0; B = 8'h0F; Bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, done, Diff, Bo} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_mid_run: busy=%b done=%b Diff=%h Bo=%h, required all 0", busy, done, Diff, Bo);
    end
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done || busy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done: activity cycles=%0d, required 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    A = 8'h35; B = 8'h12; Bi = 1'b0; start = 1'b1;
    tick();
    A = 8'h00; B = 8'h01;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    vectors++;
    if (lat !== 8 || Diff !== 8'h23 || Bo !== 8'h02) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d Diff=%h Bo=%h, required 8 23 02", lat, Diff, Bo);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || Diff !== 8'h23) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b done=%b Diff=%h, required 0 0 23", busy, done, Diff);
    end
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || Diff !== 8'h00 || Bo !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_reaccept: busy=%b Diff=%h Bo=%h, required 1 00 00", busy, Diff, Bo);
    end
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    vectors++;
    if (lat !== 8 || Diff !== 8'hFF || Bo !== 8'hFF) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d Diff=%h Bo=%h, required 8 ff ff", lat, Diff, Bo);
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] ed;
    logic [7:0] eb;
    int lat;
    int ov;
    for (int n = 0; n < 24; n++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      bi = 1'($urandom_range(0, 1));
      model(a, b, bi, ed, eb);
      run_op(a, b, bi, lat, ov);
      vectors++;
      if (lat !== 8 || Diff !== ed || Bo !== eb) begin
        miscompares++;
        $display("FAIL sweep %h-%h-%b: lat=%0d Diff=%h Bo=%h, required 8 %h %h", a, b, bi, lat, Diff, Bo, ed, eb);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; A = '0; B = '0; Bi = 1'b0;
    test_reset();
    test_vec(8'h35, 8'h12, 1'b0, 8'h23, 8'h02);
    test_vec(8'h00, 8'h01, 1'b0, 8'hFF, 8'hFF);
    test_vec(8'h80, 8'h80, 1'b1, 8'hFF, 8'hFF);
    test_vec(8'h80, 8'h80, 1'b0, 8'h00, 8'h00);
    test_vec(8'hFF, 8'h00, 1'b1, 8'hFE, 8'h00);
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
